// File: rtl/conv_layer_mem.sv
// Layer-memory responder for the convolution engine: holds the L0 (conv+ReLU) and
// L1 (max-pool) banks, serves zero-latency reads and streams both banks out once busy drops.
module conv_layer_mem #(
   parameter int DW       = 20,
   parameter int L0_DEPTH = 4096,
   parameter int L1_DEPTH = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          busy,
   input  logic          cwr,
   input  logic [11:0]   caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [11:0]   caddr_rd,
   input  logic [2:0]    csel,
   output logic [DW-1:0] cdata_rd,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic          dump_sel,
   output logic [11:0]   dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_done,
   output logic          l0_full,
   output logic          l1_full,
   output logic [2:0]    err
);

   localparam logic [2:0]  SEL_L0     = 3'b001;
   localparam logic [2:0]  SEL_L1     = 3'b011;
   localparam logic [11:0] L1_LIM     = 12'(L1_DEPTH);
   localparam logic [11:0] L0_LAST    = 12'(L0_DEPTH - 1);
   localparam logic [11:0] L1_LAST    = 12'(L1_DEPTH - 1);
   localparam logic [12:0] L0_CNT_MAX = 13'(L0_DEPTH);
   localparam logic [10:0] L1_CNT_MAX = 11'(L1_DEPTH);

   typedef enum logic [2:0] {IDLE, ARMED, DUMP_L0, DUMP_L1, DONE} state_t;

   logic [DW-1:0] r_l0 [L0_DEPTH];
   logic [DW-1:0] r_l1 [L1_DEPTH];

   state_t        r_state, w_nextState;
   logic          r_busyQ;
   logic [12:0]   r_wrCntL0, w_cntL0Next;
   logic [10:0]   r_wrCntL1, w_cntL1Next;

   logic          w_dumping, w_accept;
   logic          w_wrL0, w_wrL1, w_wrIllegal, w_wrOob;
   logic          w_rdIllegal, w_rdOob;
   logic          w_load, w_nValid, w_nSel, w_nDone;
   logic [11:0]   w_nAddr;
   logic [DW-1:0] w_beatData;

   assign w_dumping   = (r_state == DUMP_L0) || (r_state == DUMP_L1);
   assign w_accept    = dump_valid && dump_ready;
   assign w_wrL0      = cwr && !w_dumping && (csel == SEL_L0);
   assign w_wrL1      = cwr && !w_dumping && (csel == SEL_L1) && (caddr_wr < L1_LIM);
   assign w_wrIllegal = cwr && !w_dumping && (csel != SEL_L0) && (csel != SEL_L1);
   assign w_wrOob     = cwr && !w_dumping && (csel == SEL_L1) && (caddr_wr >= L1_LIM);

   // Reads bypass the clock so a same-cycle write is only seen from the next cycle on.
   always_comb begin
      cdata_rd    = '0;
      w_rdIllegal = 1'b0;
      w_rdOob     = 1'b0;
      if (crd) begin
         case (csel)
            SEL_L0: cdata_rd = r_l0[caddr_rd];
            SEL_L1: begin
               if (caddr_rd < L1_LIM) cdata_rd = r_l1[caddr_rd[9:0]];
               else                   w_rdOob  = 1'b1;
            end
            default: w_rdIllegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wrL0) r_l0[caddr_wr]       <= cdata_wr;
      if (w_wrL1) r_l1[caddr_wr[9:0]]  <= cdata_wr;
   end

   assign w_cntL0Next = (w_wrL0 && r_wrCntL0 != L0_CNT_MAX) ? r_wrCntL0 + 13'd1 : r_wrCntL0;
   assign w_cntL1Next = (w_wrL1 && r_wrCntL1 != L1_CNT_MAX) ? r_wrCntL1 + 11'd1 : r_wrCntL1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrCntL0 <= '0;
         r_wrCntL1 <= '0;
         l0_full   <= 1'b0;
         l1_full   <= 1'b0;
         err       <= '0;
         r_busyQ   <= 1'b0;
      end else begin
         r_wrCntL0 <= w_cntL0Next;
         r_wrCntL1 <= w_cntL1Next;
         l0_full   <= (w_cntL0Next == L0_CNT_MAX);
         l1_full   <= (w_cntL1Next == L1_CNT_MAX);
         err       <= err | {cwr && w_dumping, w_rdOob || w_wrOob, w_rdIllegal || w_wrIllegal};
         r_busyQ   <= busy;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (busy)                           w_nextState = ARMED;
         ARMED:   if (r_busyQ && !busy)               w_nextState = DUMP_L0;
         DUMP_L0: if (w_accept && dump_addr == L0_LAST) w_nextState = DUMP_L1;
         DUMP_L1: if (w_accept && dump_addr == L1_LAST) w_nextState = DONE;
         default: w_nextState = r_state;
      endcase
   end

   // Next beat is chosen from the beat currently on the port, so an accepted beat is
   // replaced on the very next edge and a stalled one simply is not reloaded.
   always_comb begin
      w_load   = 1'b0;
      w_nValid = dump_valid;
      w_nSel   = dump_sel;
      w_nAddr  = dump_addr;
      w_nDone  = dump_done;
      case (r_state)
         DUMP_L0: begin
            if (!dump_valid) begin
               w_load   = 1'b1;
               w_nValid = 1'b1;
               w_nSel   = 1'b0;
               w_nAddr  = '0;
            end else if (w_accept) begin
               w_load = 1'b1;
               if (dump_addr == L0_LAST) begin
                  w_nSel  = 1'b1;
                  w_nAddr = '0;
               end else begin
                  w_nAddr = dump_addr + 12'd1;
               end
            end
         end
         DUMP_L1: begin
            if (w_accept) begin
               if (dump_addr == L1_LAST) begin
                  w_nValid = 1'b0;
                  w_nDone  = 1'b1;
               end else begin
                  w_load  = 1'b1;
                  w_nAddr = dump_addr + 12'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign w_beatData = w_nSel ? r_l1[w_nAddr[9:0]] : r_l0[w_nAddr];

   always_ff @(posedge clk) begin
      if (reset) begin
         dump_valid <= 1'b0;
         dump_sel   <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         dump_done  <= 1'b0;
      end else begin
         dump_valid <= w_nValid;
         dump_sel   <= w_nSel;
         dump_addr  <= w_nAddr;
         dump_done  <= w_nDone;
         if (w_load) dump_data <= w_beatData;
      end
   end

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed bench for conv_layer_mem: table-driven read/write vectors followed by
// hand-written fill, dump, stall, mid-dump write and mid-dump reset sequences.
module tb_conv_layer_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic        cwr;
   logic [11:0] caddr_wr;
   logic [19:0] cdata_wr;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [2:0]  csel;
   logic [19:0] cdata_rd;
   logic        dump_valid;
   logic        dump_ready;
   logic        dump_sel;
   logic [11:0] dump_addr;
   logic [19:0] dump_data;
   logic        dump_done;
   logic        l0_full;
   logic        l1_full;
   logic [2:0]  err;

   int nPass  = 0;
   int nTotal = 0;

   conv_layer_mem #(.DW(20), .L0_DEPTH(4096), .L1_DEPTH(1024)) dut (
      .clk(clk), .reset(reset), .busy(busy),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_sel(dump_sel),
      .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done),
      .l0_full(l0_full), .l1_full(l1_full), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        cwr;
      logic [2:0]  csel;
      logic [11:0] waddr;
      logic [19:0] wdata;
      logic        crd;
      logic [11:0] raddr;
      logic [19:0] expRd;
      logic [2:0]  expErr;
   } vec_t;

   vec_t vecs [13];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Combinational read data is checked before the edge, sticky error flags after it.
   task automatic applyStimulus(input int idx, input vec_t v);
      cwr      = v.cwr;
      csel     = v.csel;
      caddr_wr = v.waddr;
      cdata_wr = v.wdata;
      crd      = v.crd;
      caddr_rd = v.raddr;
      #1;
      checkOutput($sformatf("vec%0d_rd", idx), 64'(cdata_rd), 64'(v.expRd));
      tick;
      checkOutput($sformatf("vec%0d_err", idx), 64'(err), 64'(v.expErr));
   endtask

   task automatic idleInputs;
      cwr = 1'b0; crd = 1'b0; csel = 3'b001;
      caddr_wr = '0; cdata_wr = '0; caddr_rd = '0;
   endtask

   task automatic pulseReset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
   endtask

   // busy high for one cycle then low; returns on the cycle the first beat is expected.
   task automatic startDump(input string tag);
      busy = 1'b1;
      tick;
      busy = 1'b0;
      tick;
      checkOutput({tag, "_noBeatYet"}, 64'(dump_valid), 64'd0);
      tick;
      checkOutput({tag, "_firstBeat"}, 64'({dump_valid, dump_sel, dump_addr}), 64'({1'b1, 1'b0, 12'd0}));
   endtask

   initial begin
      int          k;
      int          cyc;
      bit          stallDone;
      bit          wrDone;
      bit          hit;
      logic [11:0] expAddr;
      logic [19:0] expData;
      logic        expSel;

      vecs[0]  = '{1'b1, 3'b001, 12'h041, 20'h12345, 1'b0, 12'h000, 20'h00000, 3'b000};
      vecs[1]  = '{1'b0, 3'b001, 12'h000, 20'h00000, 1'b1, 12'h041, 20'h12345, 3'b000};
      vecs[2]  = '{1'b1, 3'b011, 12'h005, 20'h00111, 1'b0, 12'h000, 20'h00000, 3'b000};
      vecs[3]  = '{1'b1, 3'b011, 12'h000, 20'h00222, 1'b0, 12'h000, 20'h00000, 3'b000};
      vecs[4]  = '{1'b1, 3'b011, 12'h005, 20'h00ABC, 1'b1, 12'h005, 20'h00111, 3'b000};
      vecs[5]  = '{1'b0, 3'b011, 12'h000, 20'h00000, 1'b1, 12'h005, 20'h00ABC, 3'b000};
      vecs[6]  = '{1'b0, 3'b001, 12'h000, 20'h00000, 1'b0, 12'h041, 20'h00000, 3'b000};
      vecs[7]  = '{1'b1, 3'b010, 12'h041, 20'hFFFFF, 1'b0, 12'h000, 20'h00000, 3'b001};
      vecs[8]  = '{1'b1, 3'b011, 12'h400, 20'h77777, 1'b0, 12'h000, 20'h00000, 3'b011};
      vecs[9]  = '{1'b0, 3'b001, 12'h000, 20'h00000, 1'b1, 12'h041, 20'h12345, 3'b011};
      vecs[10] = '{1'b0, 3'b011, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h00222, 3'b011};
      vecs[11] = '{1'b0, 3'b011, 12'h000, 20'h00000, 1'b1, 12'h400, 20'h00000, 3'b011};
      vecs[12] = '{1'b0, 3'b101, 12'h000, 20'h00000, 1'b1, 12'h041, 20'h00000, 3'b011};

      idleInputs;
      busy = 1'b0;
      dump_ready = 1'b0;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      #1;
      checkOutput("resetOutputs",
                  64'({cdata_rd, dump_valid, dump_sel, dump_addr, dump_data, dump_done, l0_full, l1_full, err}),
                  64'd0);

      for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

      idleInputs;
      for (int i = 0; i < 10; i++) tick;
      checkOutput("errSticky", 64'(err), 64'(3'b011));
      pulseReset;
      checkOutput("errCleared", 64'(err), 64'd0);

      crd = 1'b1; csel = 3'b000; caddr_rd = 12'h041;
      #1;
      checkOutput("illegalRdData", 64'(cdata_rd), 64'd0);
      tick;
      checkOutput("illegalRdErr", 64'(err), 64'(3'b001));
      idleInputs;
      pulseReset;

      for (int i = 0; i < 4096; i++) begin
         cwr = 1'b1; csel = 3'b001; caddr_wr = 12'(i); cdata_wr = 20'(i);
         tick;
         if (i == 4094) checkOutput("l0NotFullYet", 64'(l0_full), 64'd0);
      end
      checkOutput("l0Full", 64'(l0_full), 64'd1);
      for (int i = 0; i < 1024; i++) begin
         cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(i); cdata_wr = ~20'(i);
         tick;
         if (i == 1022) checkOutput("l1NotFullYet", 64'(l1_full), 64'd0);
      end
      idleInputs;
      checkOutput("l1Full", 64'(l1_full), 64'd1);
      checkOutput("fillErr", 64'(err), 64'd0);

      dump_ready = 1'b1;
      startDump("dump1");
      k = 0; cyc = 0; stallDone = 1'b0; wrDone = 1'b0;
      while (k < 5120 && cyc < 6000) begin
         cyc++;
         if (dump_valid && !stallDone && !dump_sel && dump_addr == 12'd100) begin
            dump_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick;
               checkOutput("stallHold", 64'({dump_valid, dump_sel, dump_addr, dump_data}),
                           64'({1'b1, 1'b0, 12'd100, 20'd100}));
            end
            dump_ready = 1'b1;
            stallDone = 1'b1;
         end
         if (dump_valid) begin
            expSel  = (k >= 4096);
            expAddr = expSel ? 12'(k - 4096) : 12'(k);
            expData = expSel ? ~20'(expAddr) : 20'(expAddr);
            checkOutput($sformatf("beat%0d", k), 64'({dump_sel, dump_addr, dump_data}),
                        64'({expSel, expAddr, expData}));
            k++;
         end
         if (k == 300 && !wrDone) begin
            cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h300; cdata_wr = 20'hDEAD0;
            crd = 1'b1; caddr_rd = 12'd5;
            #1;
            checkOutput("rdDuringDump", 64'(cdata_rd), 64'd5);
         end
         tick;
         if (k == 300 && !wrDone) begin
            idleInputs;
            checkOutput("errWriteDuringDump", 64'(err), 64'(3'b100));
            wrDone = 1'b1;
         end
      end
      checkOutput("beatCount", 64'(k), 64'd5120);
      checkOutput("dumpDone", 64'({dump_done, dump_valid}), 64'({1'b1, 1'b0}));
      tick;
      checkOutput("doneHolds", 64'({dump_done, dump_valid}), 64'({1'b1, 1'b0}));

      pulseReset;
      checkOutput("doneCleared", 64'(dump_done), 64'd0);
      startDump("dump2");
      cyc = 0; hit = 1'b0;
      while (!hit && cyc < 6000) begin
         cyc++;
         if (dump_valid && dump_sel && dump_addr == 12'd10) hit = 1'b1;
         else tick;
      end
      checkOutput("reachL1Addr10", 64'(hit), 64'd1);
      pulseReset;
      checkOutput("midDumpReset",
                  64'({dump_valid, dump_done, dump_sel, dump_addr, l0_full, l1_full, err}), 64'd0);
      for (int i = 0; i < 5; i++) tick;
      checkOutput("idleAfterReset", 64'({dump_valid, dump_done}), 64'd0);
      startDump("dump3");

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule

// File: doc/conv_layer_mem.md
Name: conv_layer_mem

Overview:
- Responder on the far side of the convolution engine's layer-memory interface (cwr/caddr_wr/cdata_wr/crd/caddr_rd/cdata_rd/csel).
- Holds the layer-0 bank (64x64 conv+ReLU results) and the layer-1 bank (32x32 max-pool results).
- Answers read requests in the same cycle and commits writes at the clock edge.
- After the engine drops busy, streams both banks out on a ready/valid dump port for golden-compare or off-chip transfer.

Parameters:
- DW, 20, data word width (signed Q4.16 as written by the engine).
- L0_DEPTH, 4096, layer-0 bank words.
- L1_DEPTH, 1024, layer-1 bank words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- busy  in  1  engine busy flag.
- cwr  in  1  write strobe.
- caddr_wr  in  12  write address.
- cdata_wr  in  DW  write data.
- crd  in  1  read strobe.
- caddr_rd  in  12  read address.
- csel  in  3  bank select: 3'b001 = L0, 3'b011 = L1; all other codes are illegal.
- cdata_rd  out  DW  read data.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat accepted when high together with dump_valid.
- dump_sel  out  1  0 = L0 beat, 1 = L1 beat.
- dump_addr  out  12  word address of the beat.
- dump_data  out  DW  word contents.
- dump_done  out  1  high after the final L1 beat is accepted.
- l0_full  out  1  wr_cnt_l0 has reached L0_DEPTH.
- l1_full  out  1  wr_cnt_l1 has reached L1_DEPTH.
- err  out  3  sticky error flags: [0] illegal csel, [1] L1 address >= L1_DEPTH, [2] write while dumping.

Behaviour:
- Reset values: cdata_rd=0, dump_valid=0, dump_sel=0, dump_addr=0, dump_data=0, dump_done=0, l0_full=0, l1_full=0, err=0, write counters=0, FSM=IDLE. Bank contents are not cleared.
- Read path is combinational, zero latency.
  - crd=1: cdata_rd = selected bank[caddr_rd].
  - crd=0: cdata_rd = 0.
  - L1 reads use caddr_rd[9:0]; caddr_rd >= 1024 returns 0 and sets err[1].
  - Illegal csel returns 0 and sets err[0].
- Write path, on rising edge with cwr=1:
  - csel=001: L0[caddr_wr] <= cdata_wr; wr_cnt_l0++.
  - csel=011 with caddr_wr < 1024: L1[caddr_wr[9:0]] <= cdata_wr; wr_cnt_l1++.
  - caddr_wr >= 1024 on L1: no write, set err[1].
  - Illegal csel: no write, set err[0].
- Counters (13-bit L0, 11-bit L1) saturate at depth. l0_full/l1_full are registered compares. Rewriting an address still increments the counter.
- Read and write to the same bank and address in the same cycle: cdata_rd returns the old word; the new word is visible from the next cycle.
- Dump FSM states: IDLE, ARMED, DUMP_L0, DUMP_L1, DONE.
  - IDLE -> ARMED when busy=1.
  - ARMED -> DUMP_L0 on busy falling edge (registered busy_q=1, busy=0).
  - DUMP_L0 -> DUMP_L1 when beat at addr 4095 is accepted.
  - DUMP_L1 -> DONE when beat at addr 1023 is accepted.
  - DONE holds until reset.
- Dump handshake:
  - First beat presented one cycle after the FSM enters DUMP_L0: dump_addr=0, dump_sel=0.
  - Beat outputs are registered. While dump_valid=1 && dump_ready=0, dump_addr/dump_sel/dump_data hold stable.
  - Each accepted beat advances the address by 1 and the next beat appears the following cycle, so throughput is 1 beat/cycle with dump_ready held high.
  - L1 address restarts at 0 with dump_sel=1.
- dump_done rises the cycle after the last beat is accepted; dump_valid is 0 at the same time.
- cwr=1 during DUMP_L0/DUMP_L1: write is ignored and err[2] is set. crd reads are still served.
- busy re-asserting during a dump is ignored; the dump completes.
- Reset asserted mid-dump returns the FSM to IDLE and all outputs to reset values. Bank contents are retained but unspecified for verification.

Test Plan:
- Write L0[0x041]=0x12345 (csel=001), then crd=1, caddr_rd=0x041 the next cycle -> cdata_rd=0x12345 combinationally in that cycle.
- Same cycle: write L1[5]=0x00ABC and read L1[5], which previously held 0x00111 -> cdata_rd=0x00111 this cycle, 0x00ABC the next cycle.
- csel=3'b010 write, then csel=011 write to addr 0x400 -> no bank change, err=3'b011. err stays set through 10 idle cycles and clears only on reset.
- Write all 4096 L0 words (data=addr) and all 1024 L1 words (data=~addr) -> l0_full=1, l1_full=1. Then busy 1->0 with dump_ready=1 -> 5120 beats in order (L0 0..4095, then L1 0..1023) with matching data; dump_done=1 one cycle after the last beat.
- During the dump, drop dump_ready for 3 cycles at L0 addr 100 -> dump_addr stays 100 and dump_data unchanged; no beat lost or duplicated. Pulse cwr mid-dump -> err[2]=1 and bank unchanged.
- Assert reset for 1 cycle at L1 dump addr 10 -> next cycle dump_valid=0, dump_done=0, FSM in IDLE, counters 0. A new busy high/low cycle restarts the dump at L0 addr 0.
